seq_arith_unit: RTL and testbench
=================================

Name: seq_arith_unit

Overview:
Responder-side arithmetic unit that the stimulus/checker bench drives: it accepts operand pairs on a start strobe and returns either a sum or a product. Addition completes in one cycle. Multiplication uses an iterative shift-add datapath with a fixed latency. The result is held stable after completion, so a bench that samples `result` a fixed number of cycles after applying operands sees a settled value. It sits behind `dut_wrapper` as the `adder_cla`/`multiplier`-style operating target.

Parameters:
- WIDTH, 8, operand width in bits; `result` is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only when idle.
- op  input  1  0 = add, 1 = multiply; sampled with start.
- a  input  WIDTH  operand A (multiplicand); sampled with start.
- b  input  WIDTH  operand B (multiplier); sampled with start.
- busy  output  1  high while a multiply is iterating.
- done  output  1  one-cycle completion pulse.
- result  output  2*WIDTH  last completed result; held until the next completion.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. On reset: state=IDLE, busy=0, done=0, result=0, all internal registers=0.
- States: IDLE and MUL. busy = (state==MUL).
- Acceptance: start=1 while in IDLE (cycle 0) latches op, a and b.
- start while MUL: ignored, with no queuing and no effect on the operation in flight.
- Add (op=0):
  - At the end of cycle 0, result <= zero-extended {carry, a+b} (WIDTH+1 significant bits; upper bits 0) and done <= 1.
  - done is visible in cycle 1, so latency is 1. State stays IDLE.
- Multiply (op=1):
  - At the end of cycle 0: mcand <= zero-extended a (2*WIDTH bits), mplier <= b, acc <= 0, cnt <= 0, state <= MUL.
  - Each MUL cycle (cycles 1..WIDTH): if mplier[0], acc <= acc + mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
  - On the MUL cycle with cnt==WIDTH-1: result <= final acc, done <= 1, state <= IDLE.
  - done and the product are visible in cycle WIDTH+1.
  - Latency is fixed at WIDTH+1 regardless of operand values; there is no early termination on zero operands.
- done:
  - Asserted for exactly one cycle per completed operation.
  - Deasserted in every other cycle, including the cycle an operation is accepted.
- result:
  - Updated only on completion.
  - Not cleared on start; holds its value through idle and busy periods.
- Back-to-back:
  - start in the same cycle that done is high is accepted (state is IDLE).
  - Consecutive adds can produce done on every cycle.
- Width rules:
  - Product is exact for all inputs; maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - Sum maximum is 2^(WIDTH+1)-2.
  - acc never overflows.
- Reset mid-operation: returns to IDLE on the next edge; busy=0, done=0, result=0; the in-flight operation is discarded and produces no done.
- Reset has priority over start in the same cycle.
- op, a and b changing while busy have no effect on the operation in flight.

Test Plan:
- Reset, then add a=255, b=1 in cycle 0 -> done=1 and result=256 in cycle 1; done=0 in cycle 2; result still 256 in cycle 5.
- Multiply a=255, b=255 (WIDTH=8) -> busy=1 in cycles 1..8; done=1 and result=65025 in cycle 9 only; busy=0 from cycle 9.
- Multiply a=0, b=200 -> done in cycle 9 (fixed latency), result=0. Then multiply a=127, b=129 -> result=16383.
- Start an add of 5+3 in cycle 3 of a 12*10 multiply -> add ignored; result=120 at cycle 9; no extra done pulse.
- Assert reset in cycle 4 of a 200*200 multiply -> busy=0 and result=0 from cycle 5; no done ever observed; a following add 10+4 gives done and result=14 one cycle after acceptance.
- Back-to-back: a multiply done in cycle 9 with start (add 15+2) in cycle 9 -> done=1, result=17 in cycle 10.
- Directed add set (5+3, 10+4, 15+2, 0+100, 128+128, 127+129) sampled 2 cycles after apply -> 8, 14, 17, 100, 256, 256.

Source files
------------

// File: rtl/seq_arith_unit.sv
// -----------------------------------------------------------------------------
// seq_arith_unit
//
// Small responder-side arithmetic unit. Each request carries an operand pair
// and an opcode, and the unit returns either a sum or a product.
//   - Add (op=0) finishes in one cycle. The unit stays idle, so a new request
//     can be accepted on every cycle.
//   - Multiply (op=1) uses an iterative shift-add datapath. It always takes
//     WIDTH+1 cycles from acceptance to the done pulse, whatever the operand
//     values.
// `result` changes only when an operation completes. A checker that samples
// it a fixed number of cycles after issuing a request therefore sees a
// settled value.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   start   in   request strobe; only looked at while idle
//   op      in   0 = add, 1 = multiply; sampled with start
//   a       in   [WIDTH-1:0]   operand A / multiplicand; sampled with start
//   b       in   [WIDTH-1:0]   operand B / multiplier;   sampled with start
//   busy    out  high while a multiply is iterating
//   done    out  one-cycle completion pulse
//   result  out  [2*WIDTH-1:0] last completed result, held until the next one
// -----------------------------------------------------------------------------
module seq_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [RW-1:0]   acc, acc_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [RW-1:0]   result_nxt;
    logic            done_nxt;

    // Accumulator value after the current step. The completion cycle also
    // uses it, so the last partial product lands in result on the same edge.
    logic [RW-1:0]   acc_sum;

    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign busy    = (state == MUL);

    // Next-state and datapath control
    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        result_nxt = result;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (!op) begin
                        // Zero-extending to RW bits keeps the carry out of a+b.
                        result_nxt = RW'(a) + RW'(b);
                        done_nxt   = 1'b1;
                    end else begin
                        mcand_nxt  = RW'(a);
                        mplier_nxt = b;
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        state_nxt  = MUL;
                    end
                end
            end

            MUL: begin
                // One multiplier bit per cycle. The loop always runs WIDTH
                // steps with no early exit, so the latency stays fixed.
                acc_nxt    = acc_sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == LAST) begin
                    result_nxt = acc_sum;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            result <= result_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_arith_unit
//
// Directed and randomized bench for seq_arith_unit (WIDTH=8). The reference
// model is plain arithmetic: a sum or product, a fixed latency of 1 (add) or
// WIDTH+1 (multiply), and a record of the last completed result that result
// must hold between completions.
// -----------------------------------------------------------------------------
module tb_seq_arith_unit;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;

    int errors = 0;
    int checks = 0;
    int last_res = 0;     // model: last completed result

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Hard stop if the run ever overshoots its expected length.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one cycle and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Idle cycles: there must be no done pulse and result must hold.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick;
            chk({tag, "_idle_done"}, 32'(done), 0);
            chk({tag, "_idle_busy"}, 32'(busy), 0);
            chk({tag, "_idle_res"},  32'(result), last_res);
        end
    endtask

    // Issue one operation in the current cycle (cycle 0) and follow it to
    // completion. With noise set, the inputs are disturbed while the multiply
    // is busy; cycle 3 always carries a 5+3 add request.
    task automatic do_op(input logic o, input int x, input int y,
                         input bit noise, input string tag);
        int lat;
        int exp;
        lat = o ? W + 1 : 1;
        exp = o ? x * y : x + y;
        start = 1'b1;
        op    = o;
        a     = W'(x);
        b     = W'(y);
        for (int k = 1; k <= lat; k++) begin
            tick;
            if (k < lat) begin
                chk({tag, "_done_early"}, 32'(done), 0);
                chk({tag, "_busy"},       32'(busy), 1);
                chk({tag, "_res_hold"},   32'(result), last_res);
            end else begin
                chk({tag, "_done"},   32'(done), 1);
                chk({tag, "_busy_lo"}, 32'(busy), 0);
                chk({tag, "_res"},    32'(result), exp);
            end
            if (noise && k < lat) begin
                if (k == 3) begin
                    start = 1'b1; op = 1'b0; a = W'(5); b = W'(3);
                end else begin
                    start = 1'($urandom);
                    op    = 1'($urandom);
                    a     = W'($urandom);
                    b     = W'($urandom);
                end
            end else begin
                start = 1'b0;
            end
        end
        last_res = exp;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        tick;
        tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_res",  32'(result), 0);
        reset = 1'b0;
        idle(1, "post_rst");

        // Add with carry out; the result holds through idle cycles 2..5.
        do_op(1'b0, 255, 1, 1'b0, "add255_1");
        idle(4, "add255_1");

        // Largest product, a zero operand (fixed latency), then a mixed case.
        do_op(1'b1, 255, 255, 1'b0, "mul255_255");
        idle(1, "mul255_255");
        do_op(1'b1, 0, 200, 1'b0, "mul0_200");
        idle(1, "mul0_200");
        do_op(1'b1, 127, 129, 1'b0, "mul127_129");
        idle(1, "mul127_129");

        // Add request during a busy multiply is ignored.
        do_op(1'b1, 12, 10, 1'b1, "mul12_10_noise");
        idle(3, "mul12_10_noise");

        // Reset in cycle 4 of a multiply, with start also asserted.
        start = 1'b1; op = 1'b1; a = W'(200); b = W'(200);
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        chk("mid_busy_before_rst", 32'(busy), 1);
        reset = 1'b1; start = 1'b1; op = 1'b0; a = W'(3); b = W'(4);
        tick;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_res",  32'(result), 0);
        last_res = 0;
        reset = 1'b0; start = 1'b0;
        idle(12, "mid_rst");
        do_op(1'b0, 10, 4, 1'b0, "add10_4");
        idle(1, "add10_4");

        // Reset takes priority over start while idle.
        reset = 1'b1; start = 1'b1; op = 1'b0; a = W'(50); b = W'(50);
        tick;
        chk("rst_prio_done", 32'(done), 0);
        chk("rst_prio_res",  32'(result), 0);
        last_res = 0;
        reset = 1'b0; start = 1'b0;
        idle(2, "rst_prio");

        // Back-to-back: the add is issued in the same cycle as the multiply's done.
        do_op(1'b1, 9, 7, 1'b0, "b2b_mul");
        do_op(1'b0, 15, 2, 1'b0, "b2b_add");
        idle(1, "b2b_add");

        // Directed adds, each result re-checked two cycles after it was issued.
        begin
            int da[6] = '{5, 10, 15, 0, 128, 127};
            int db[6] = '{3, 4, 2, 100, 128, 129};
            for (int i = 0; i < 6; i++) begin
                do_op(1'b0, da[i], db[i], 1'b0, $sformatf("dadd%0d", i));
                idle(1, $sformatf("dadd%0d", i));
            end
        end

        // Consecutive adds give a done pulse on every cycle.
        do_op(1'b0, 1, 2, 1'b0, "stream0");
        do_op(1'b0, 200, 100, 1'b0, "stream1");
        do_op(1'b0, 255, 255, 1'b0, "stream2");
        idle(1, "stream");

        // Randomized operations with random noise and random idle gaps.
        for (int n = 0; n < 40; n++) begin
            logic o;
            int   x;
            int   y;
            int   gap;
            o   = 1'($urandom);
            x   = int'($urandom_range(0, (1 << W) - 1));
            y   = int'($urandom_range(0, (1 << W) - 1));
            do_op(o, x, y, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
